// File: rtl/chacha_block_engine.sv
// ChaCha block function engine: DOUBLE_ROUNDS column/diagonal round pairs on
// QR_LANES quarter-round units, feed-forward add, multi-block streaming output.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// LOAD  | copy saved input state into the working state
// ROUND | apply QR_LANES quarter rounds per cycle from the fixed schedule
// ADD   | feed-forward add, present block on the output
// HOLD  | hold output until consumer accepts, then next block or IDLE
module chacha_block_engine #(
  parameter int DOUBLE_ROUNDS = 10,
  parameter int QR_LANES      = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [511:0]     in_state,
  input  logic [CNT_W-1:0] in_num_blocks,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [511:0]     out_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_produced
);

  localparam int ROUND_CYCLES = DOUBLE_ROUNDS * 8 / QR_LANES;
  localparam int STEP_W       = $clog2(ROUND_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_ADD,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } qr_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       work     [16];
  logic [31:0]       work_nxt [16];
  logic [31:0]       orig     [16];
  logic [CNT_W-1:0]  remaining;
  logic [STEP_W-1:0] step_cnt;
  logic [2:0]        qr_base;
  logic              accept;
  logic              step_last;
  logic              handshake;
  logic              final_block;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic qr_t quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    a = a_in;
    b = b_in;
    c = c_in;
    d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return '{a: a, b: b, c: c, d: d};
  endfunction

  // Word indices {row,col} for schedule entry q: 0..3 columns, 4..7 diagonals.
  function automatic logic [15:0] qr_words(input logic [2:0] q);
    logic [1:0] k;
    k = q[1:0];
    if (!q[2]) begin
      return {2'd0, k, 2'd1, k, 2'd2, k, 2'd3, k};
    end
    return {2'd0, k, 2'd1, k + 2'd1, 2'd2, k + 2'd2, 2'd3, k + 2'd3};
  endfunction

  assign accept      = in_valid && in_ready;
  assign step_last   = (step_cnt == STEP_W'(ROUND_CYCLES - 1));
  assign handshake   = (state == S_HOLD) && out_ready;
  assign final_block = (remaining == CNT_W'(1));
  assign in_ready    = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ROUND;
      S_ROUND: if (step_last) state_nxt = S_ADD;
      S_ADD:   state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = final_block ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lanes in one cycle use consecutive schedule entries, which never share words.
  always_comb begin
    logic [15:0] idx;
    qr_t         res;
    work_nxt = work;
    idx      = '0;
    res      = '0;
    for (int l = 0; l < QR_LANES; l++) begin
      idx = qr_words(qr_base + 3'(l));
      res = quarter_round(work[idx[15:12]], work[idx[11:8]], work[idx[7:4]], work[idx[3:0]]);
      work_nxt[idx[15:12]] = res.a;
      work_nxt[idx[11:8]]  = res.b;
      work_nxt[idx[7:4]]   = res.c;
      work_nxt[idx[3:0]]   = res.d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        work[i] <= '0;
        orig[i] <= '0;
      end
      remaining       <= '0;
      step_cnt        <= '0;
      qr_base         <= '0;
      out_state       <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      blocks_produced <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) orig[i] <= in_state[32*i +: 32];
            remaining <= (in_num_blocks == '0) ? CNT_W'(1) : in_num_blocks;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < 16; i++) work[i] <= orig[i];
          step_cnt <= '0;
          qr_base  <= '0;
        end
        S_ROUND: begin
          for (int i = 0; i < 16; i++) work[i] <= work_nxt[i];
          step_cnt <= step_cnt + 1'b1;
          qr_base  <= qr_base + 3'(QR_LANES);
        end
        S_ADD: begin
          for (int i = 0; i < 16; i++) out_state[32*i +: 32] <= work[i] + orig[i];
          out_valid <= 1'b1;
          out_last  <= final_block;
        end
        S_HOLD: begin
          if (handshake) begin
            blocks_produced <= blocks_produced + 1'b1;
            remaining       <= remaining - 1'b1;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            // Next block of the request: bump only the 32-bit counter word.
            if (!final_block) orig[12] <= orig[12] + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_engine.sv
// Bench for chacha_block_engine: four instances (lanes 1/2/4, one single double
// round) checked against a reference block model through an expected-block queue.
`timescale 1ns/1ps
module tb_chacha_block_engine;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [511:0] in_state;
  logic [7:0]   in_num_blocks;
  logic         out_ready;
  logic         in_valid        [NI];
  logic         in_ready        [NI];
  logic [511:0] out_state       [NI];
  logic         out_valid       [NI];
  logic         out_last        [NI];
  logic         busy            [NI];
  logic [7:0]   blocks_produced [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    chacha_block_engine #(
      .DOUBLE_ROUNDS(g == 3 ? 1 : 10),
      .QR_LANES     (g == 1 ? 2 : (g == 2 ? 4 : 1)),
      .CNT_W        (8)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .in_state       (in_state),
      .in_num_blocks  (in_num_blocks),
      .in_valid       (in_valid[g]),
      .in_ready       (in_ready[g]),
      .out_state      (out_state[g]),
      .out_valid      (out_valid[g]),
      .out_ready      (out_ready),
      .out_last       (out_last[g]),
      .busy           (busy[g]),
      .blocks_produced(blocks_produced[g])
    );
  end

  typedef struct {
    logic [511:0] st;
    logic         last;
  } exp_t;

  typedef struct {
    int           id;
    logic [511:0] st;
    logic [7:0]   nb;
    int           dr;
    int           lat;
    logic [511:0] exp_first;
  } vec_t;

  exp_t       sb_q[$];
  int         n_tests;
  int         n_fail;
  int         cyc;
  logic [7:0] bp_exp [NI];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] qr_ref(input logic [511:0] s, input int ia, input int ib,
                                          input int ic, input int id);
    logic [31:0] a, b, c, d;
    a = s[32*ia +: 32]; b = s[32*ib +: 32]; c = s[32*ic +: 32]; d = s[32*id +: 32];
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
    s[32*ia +: 32] = a; s[32*ib +: 32] = b; s[32*ic +: 32] = c; s[32*id +: 32] = d;
    return s;
  endfunction

  function automatic logic [511:0] chacha_ref(input logic [511:0] st, input int dr);
    logic [511:0] w;
    logic [511:0] r;
    w = st;
    for (int n = 0; n < dr; n++) begin
      w = qr_ref(w, 0, 4, 8, 12);  w = qr_ref(w, 1, 5, 9, 13);
      w = qr_ref(w, 2, 6, 10, 14); w = qr_ref(w, 3, 7, 11, 15);
      w = qr_ref(w, 0, 5, 10, 15); w = qr_ref(w, 1, 6, 11, 12);
      w = qr_ref(w, 2, 7, 8, 13);  w = qr_ref(w, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[32*i +: 32] + st[32*i +: 32];
    return r;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] s;
    for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Push expected blocks k_from..n-1 of a request (counter word 12 increments).
  task automatic push_blocks(input logic [511:0] st, input logic [7:0] nb, input int dr,
                             input int k_from);
    int   n;
    exp_t e;
    logic [511:0] s;
    n = (nb == 0) ? 1 : int'(nb);
    for (int k = k_from; k < n; k++) begin
      s = st;
      s[32*12 +: 32] = st[32*12 +: 32] + 32'(k);
      e.st   = chacha_ref(s, dr);
      e.last = (k == n - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic send(input int id, input logic [511:0] st, input logic [7:0] nb, output int t0);
    @(negedge clk);
    check($sformatf("in_ready_idle[%0d]", id), in_ready[id], 1'b1);
    in_state      = st;
    in_num_blocks = nb;
    in_valid[id]  = 1'b1;
    @(posedge clk);
    #1;
    in_valid[id] = 1'b0;
    t0 = cyc;
  endtask

  // Wait for a block, compare with the queue head, then take the handshake.
  task automatic collect(input int id, input int lat, inout int t0, input string name,
                         output logic [511:0] got);
    int   waited;
    exp_t e;
    waited = 0;
    got    = '0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid[id] && waited < lat + 50);
    if (!out_valid[id]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no out_valid after %0d cycles, required latency %0d", name, waited, lat);
      return;
    end
    got = out_state[id];
    check({name, "_latency"}, 512'(cyc - t0), 512'(lat));
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected: output with empty scoreboard, got %h", name, got);
      return;
    end
    e = sb_q.pop_front();
    check({name, "_state"}, got, e.st);
    check({name, "_last"}, out_last[id], e.last);
    @(posedge clk);
    #1;
    t0 = cyc;
    bp_exp[id] = bp_exp[id] + 8'd1;
    check({name, "_blocks_produced"}, blocks_produced[id], bp_exp[id]);
    check({name, "_valid_drop"}, out_valid[id], 1'b0);
    check({name, "_in_ready_after"}, in_ready[id], e.last);
  endtask

  logic [511:0] rfc_st;
  logic [511:0] qr_st;
  logic [511:0] got;
  logic [511:0] st;
  vec_t         tbl [6];
  int           t0;
  int           lat;
  logic         seen;

  initial begin
    logic [31:0] rfc_w [16];
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    out_ready     = 1'b1;
    in_state      = '0;
    in_num_blocks = '0;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0;
      bp_exp[i]   = '0;
    end

    rfc_w = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
              32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
              32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
              32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    for (int i = 0; i < 16; i++) rfc_st[32*i +: 32] = rfc_w[i];
    qr_st = '0;
    qr_st[32*0 +: 32]  = 32'h11111111;
    qr_st[32*4 +: 32]  = 32'h01020304;
    qr_st[32*8 +: 32]  = 32'h9b8d6f43;
    qr_st[32*12 +: 32] = 32'h01234567;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_in_ready[%0d]", i), in_ready[i], 1'b1);
      check($sformatf("reset_busy[%0d]", i), busy[i], 1'b0);
      check($sformatf("reset_out_valid[%0d]", i), out_valid[i], 1'b0);
      check($sformatf("reset_out_last[%0d]", i), out_last[i], 1'b0);
      check($sformatf("reset_bp[%0d]", i), blocks_produced[i], 8'd0);
      check($sformatf("reset_out_state[%0d]", i), out_state[i], '0);
    end
    rst = 1'b0;

    // Single quarter round probe on the one-double-round instance.
    send(3, qr_st, 8'd1, t0);
    push_blocks(qr_st, 8'd1, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("qr_a", g_dut[3].u_dut.work[0],  32'hea2a92f4);
    check("qr_b", g_dut[3].u_dut.work[4],  32'hcb1cf8ce);
    check("qr_c", g_dut[3].u_dut.work[8],  32'h4581472e);
    check("qr_d", g_dut[3].u_dut.work[12], 32'h5881c4bb);
    collect(3, 10, t0, "qr_block", got);

    tbl[0] = '{0, rfc_st, 8'd1, 10, 82, chacha_ref(rfc_st, 10)};
    tbl[1] = '{1, rfc_st, 8'd1, 10, 42, chacha_ref(rfc_st, 10)};
    tbl[2] = '{2, rfc_st, 8'd1, 10, 22, chacha_ref(rfc_st, 10)};
    st = rand_state();
    tbl[3] = '{3, st, 8'd1, 1, 10, chacha_ref(st, 1)};
    st = rand_state();
    tbl[4] = '{2, st, 8'd0, 10, 22, chacha_ref(st, 10)};
    st = rand_state();
    tbl[5] = '{0, st, 8'd2, 10, 82, chacha_ref(st, 10)};

    for (int v = 0; v < 6; v++) begin
      exp_t e;
      int   n;
      e.st   = tbl[v].exp_first;
      e.last = (tbl[v].nb <= 8'd1);
      sb_q.push_back(e);
      push_blocks(tbl[v].st, tbl[v].nb, tbl[v].dr, 1);
      send(tbl[v].id, tbl[v].st, tbl[v].nb, t0);
      n = (tbl[v].nb == 0) ? 1 : int'(tbl[v].nb);
      for (int k = 0; k < n; k++) begin
        collect(tbl[v].id, tbl[v].lat, t0, $sformatf("vec%0d_blk%0d", v, k), got);
        if (v < 3) begin
          check($sformatf("vec%0d_w0", v), got[31:0],    32'he4e7f110);
          check($sformatf("vec%0d_w1", v), got[63:32],   32'h15593bd1);
          check($sformatf("vec%0d_w2", v), got[95:64],   32'h1fdd0f50);
          check($sformatf("vec%0d_w3", v), got[127:96],  32'hc47120a3);
          check($sformatf("vec%0d_w15", v), got[511:480], 32'h4e3c50a2);
        end
      end
    end

    // Multi-block request crossing the 32-bit counter wrap.
    st = rand_state();
    st[32*12 +: 32] = 32'hffffffff;
    st[32*13 +: 32] = 32'hdeadbeef;
    push_blocks(st, 8'd3, 10, 0);
    send(2, st, 8'd3, t0);
    for (int k = 0; k < 3; k++) collect(2, 22, t0, $sformatf("wrap_blk%0d", k), got);

    // Backpressure: output held for 10 cycles, then handshake and next block.
    begin
      exp_t e;
      int   waited;
      out_ready = 1'b0;
      st = rand_state();
      push_blocks(st, 8'd2, 10, 0);
      send(2, st, 8'd2, t0);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!out_valid[2] && waited < 80);
      e = sb_q.pop_front();
      check("bp_latency", 512'(cyc - t0), 512'd22);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check($sformatf("bp_state_c%0d", k), out_state[2], e.st);
        check($sformatf("bp_valid_c%0d", k), out_valid[2], 1'b1);
        check($sformatf("bp_last_c%0d", k), out_last[2], 1'b0);
        check($sformatf("bp_in_ready_c%0d", k), in_ready[2], 1'b0);
      end
      check("bp_count_held", blocks_produced[2], bp_exp[2]);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      bp_exp[2] = bp_exp[2] + 8'd1;
      check("bp_count_after", blocks_produced[2], bp_exp[2]);
      collect(2, 22, t0, "bp_blk1", got);
    end

    // Reset mid-ROUND; a request offered while busy must leave no trace.
    send(0, rfc_st, 8'd3, t0);
    while (cyc - t0 < 20) @(negedge clk);
    in_state     = rand_state();
    in_valid[0]  = 1'b1;
    repeat (3) @(negedge clk);
    in_valid[0]  = 1'b0;
    while (cyc - t0 < 40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) bp_exp[i] = '0;
    check("rst_in_ready", in_ready[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_bp", blocks_produced[0], 8'd0);
    check("rst_out_state", out_state[0], '0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (out_valid[0] || busy[0]) seen = 1'b1;
    end
    check("rst_no_output", seen, 1'b0);

    // blocks_produced wrap on the fast instance.
    st = rand_state();
    push_blocks(st, 8'd255, 1, 0);
    send(3, st, 8'd255, t0);
    for (int k = 0; k < 255; k++) collect(3, 10, t0, $sformatf("cnt_blk%0d", k), got);
    check("cnt_255", blocks_produced[3], 8'd255);
    st = rand_state();
    push_blocks(st, 8'd1, 1, 0);
    send(3, st, 8'd1, t0);
    collect(3, 10, t0, "cnt_wrap", got);
    check("cnt_wrapped", blocks_produced[3], 8'd0);

    check("sb_empty", 512'(sb_q.size()), 512'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
